// File: rtl/dm_pkg.sv
// Shared types and helpers for the handshaked data memory.
package dm_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } dm_state_e;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dm_array.sv
// Single-port DEPTH x DATA_W storage with byte-enabled synchronous write and synchronous read.
module dm_array
  import dm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic                      re,
  input  logic [nbytes(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata
);

  localparam int BYTES = nbytes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/datamem_hs.sv
// Data memory with request/response handshake, fixed response latency and a
// zero-fill sweep of the whole array after every reset.
module datamem_hs
  import dm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [nbytes(DATA_W)-1:0] req_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata
);

  localparam int BYTES = nbytes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAT_W = cnt_width(LATENCY + 1);

  dm_state_e         state, state_nx;
  logic [ADDR_W:0]   init_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              rd_flag;
  logic              accept;
  logic              arr_we, arr_re;
  logic [BYTES-1:0]  arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  // Array read register holds the captured word; writes report zero.
  assign rsp_rdata = rd_flag ? arr_rdata : '0;

  // The zero-fill sweep owns the array port while in INIT.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_be    = req_be;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = init_cnt[ADDR_W-1:0];
      arr_wdata = '0;
    end else if (accept) begin
      arr_we = req_write;
      arr_re = !req_write;
    end
  end

  dm_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .be   (arr_be),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT: if (init_cnt == (ADDR_W+1)'(DEPTH - 1)) state_nx = IDLE;
      IDLE: if (req_valid) state_nx = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (lat_cnt == LAT_W'(LATENCY - 1)) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt <= '0;
      lat_cnt  <= '0;
      rd_flag  <= 1'b0;
    end else begin
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (accept) begin
        lat_cnt <= LAT_W'(1);
        rd_flag <= !req_write;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

endmodule
